// File: rtl/hazard_if.sv
// Datapath <-> hazard unit bundle: register addresses and control bits in,
// stall/flush/forward selects and status out.
interface hazard_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
);
    logic [REG_ADDR_WIDTH-1:0] Rs1D, Rs2D;
    logic [REG_ADDR_WIDTH-1:0] Rs1E, Rs2E, RdE;
    logic [REG_ADDR_WIDTH-1:0] RdM, RdW;
    logic RegWriteM, RegWriteW;
    logic ResultSrcE0, PCSrcE;
    logic MemReqM, MemReadyM;
    logic CntClear;
    logic StallF, StallD, StallE, StallM;
    logic FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardEE;
    logic MemTimeout;
    logic [CNT_WIDTH-1:0] StallCount, FlushCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE,
        output MemReqM, MemReadyM, CntClear,
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardEE, MemTimeout,
        input  StallCount, FlushCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE,
        input  MemReqM, MemReadyM, CntClear,
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW,
        output ForwardAE, ForwardEE, MemTimeout,
        output StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_unit.sv
// Hazard/forwarding controller: post-reset flush, memory wait with
// timeout detection, saturating stall and flush counters.
module hazard_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT        = 16
) (
    input logic clk,
    input logic reset,
    hazard_if.slave hz
);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {INIT, RUN, MEM_WAIT} state_t;

    state_t state;
    logic [WW-1:0] wait_cnt;
    logic mem_timeout;
    logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;

    logic lw_stall, mem_stall, flush_br, stall_inc;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_w;
    logic [1:0] fwd_a, fwd_b;

    assign lw_stall = hz.ResultSrcE0 && (hz.RdE != '0)
                   && ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));
    assign mem_stall = hz.MemReqM && !hz.MemReadyM;

    always_comb begin
        fwd_a = 2'd0;
        fwd_b = 2'd0;
        if (hz.RegWriteM && hz.RdM != '0 && hz.Rs1E == hz.RdM)
            fwd_a = 2'd2;
        else if (hz.RegWriteW && hz.RdW != '0 && hz.Rs1E == hz.RdW)
            fwd_a = 2'd1;
        if (hz.RegWriteM && hz.RdM != '0 && hz.Rs2E == hz.RdM)
            fwd_b = 2'd2;
        else if (hz.RegWriteW && hz.RdW != '0 && hz.Rs2E == hz.RdW)
            fwd_b = 2'd1;
    end

    // A branch seen during a memory wait stays frozen in E, so it is
    // applied once the wait ends rather than being dropped.
    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        stall_m  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_w  = 1'b0;
        flush_br = 1'b0;
        if (state == INIT) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else begin
            stall_f  = lw_stall;
            stall_d  = lw_stall;
            flush_e  = lw_stall | hz.PCSrcE;
            flush_d  = hz.PCSrcE;
            flush_br = hz.PCSrcE;
        end
    end

    assign stall_inc = (state != INIT) && (lw_stall || mem_stall);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= INIT;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            unique case (state)
                INIT:     state <= RUN;
                RUN:      state <= mem_stall ? MEM_WAIT : RUN;
                MEM_WAIT: state <= mem_stall ? MEM_WAIT : RUN;
                default:  state <= INIT;
            endcase
            if (mem_stall) begin
                if (wait_cnt != WW'(TIMEOUT))
                    wait_cnt <= wait_cnt + WW'(1);
                if (wait_cnt >= WW'(TIMEOUT - 1))
                    mem_timeout <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (hz.CntClear) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            if (flush_br && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);
        end
    end

    assign hz.StallF     = stall_f;
    assign hz.StallD     = stall_d;
    assign hz.StallE     = stall_e;
    assign hz.StallM     = stall_m;
    assign hz.FlushD     = flush_d;
    assign hz.FlushE     = flush_e;
    assign hz.FlushW     = flush_w;
    assign hz.ForwardAE  = fwd_a;
    assign hz.ForwardEE  = fwd_b;
    assign hz.MemTimeout = mem_timeout;
    assign hz.StallCount = stall_cnt;
    assign hz.FlushCount = flush_cnt;
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Hazard and forwarding controller for the 5-stage pipelined core. It consumes the register addresses and control bits exported by the datapath and drives the stall, flush and forward-select inputs back to it. It adds three sequential pieces on top of the classic combinational hazard logic:
- a post-reset pipeline-flush sequencer;
- a data-memory wait state with timeout detection;
- saturating stall and flush performance counters.

Parameters:
REG_ADDR_WIDTH, 5, register address width (matches reg_addr_t)
CNT_WIDTH, 32, width of each performance counter
TIMEOUT, 16, maximum consecutive MEM_WAIT cycles before MemTimeout is set

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
Rs1D  in  REG_ADDR_WIDTH  decode-stage source 1
Rs2D  in  REG_ADDR_WIDTH  decode-stage source 2
Rs1E  in  REG_ADDR_WIDTH  execute-stage source 1
Rs2E  in  REG_ADDR_WIDTH  execute-stage source 2
RdE  in  REG_ADDR_WIDTH  execute-stage destination
RdM  in  REG_ADDR_WIDTH  memory-stage destination
RdW  in  REG_ADDR_WIDTH  writeback-stage destination
RegWriteM  in  1  memory-stage register write enable
RegWriteW  in  1  writeback-stage register write enable
ResultSrcE0  in  1  execute-stage instruction is a load
PCSrcE  in  1  taken branch/jump resolved in execute
MemReqM  in  1  memory-stage load/store active
MemReadyM  in  1  data memory completes the access this cycle
CntClear  in  1  synchronous clear of both counters
StallF  out  1  hold PC register
StallD  out  1  hold IF/ID register
StallE  out  1  hold ID/EX register
StallM  out  1  hold EX/MEM register
FlushD  out  1  clear IF/ID register
FlushE  out  1  clear ID/EX register
FlushW  out  1  clear MEM/WB register (insert bubble)
ForwardAE  out  2  SrcA select: 0 RD1E, 1 ResultW, 2 ALUResultM
ForwardEE  out  2  WriteData select: 0 RD2E, 1 ResultW, 2 ALUResultM
MemTimeout  out  1  sticky error: memory wait exceeded TIMEOUT
StallCount  out  CNT_WIDTH  cycles with lwStall or memStall asserted
FlushCount  out  CNT_WIDTH  cycles in which a branch flush was applied

Behaviour:
- Forwarding (combinational, in all states):
  - ForwardAE = 2 if RegWriteM && RdM!=0 && Rs1E==RdM.
  - Else ForwardAE = 1 if RegWriteW && RdW!=0 && Rs1E==RdW.
  - Else ForwardAE = 0.
  - ForwardEE follows the same rule using Rs2E. The M stage has priority over W.
  - The value 3 is never driven.
- Hazard terms:
  - lwStall = ResultSrcE0 && RdE!=0 && (Rs1D==RdE || Rs2D==RdE).
  - memStall = MemReqM && !MemReadyM.
- FSM states: INIT, RUN, MEM_WAIT. The FSM is in INIT while reset is asserted.
  - INIT: StallF=1, FlushD=1, FlushE=1, all other stalls/flushes 0. Unconditionally moves to RUN on the next edge, so INIT lasts exactly 1 cycle after reset deasserts.
  - RUN with memStall: outputs follow the MEM_WAIT rules in the same cycle; next state is MEM_WAIT.
  - RUN without memStall:
    - StallF = StallD = lwStall.
    - FlushE = lwStall | PCSrcE.
    - FlushD = PCSrcE.
    - StallE = StallM = FlushW = 0.
  - MEM_WAIT (entered or remaining with memStall=1):
    - StallF = StallD = StallE = StallM = 1, FlushW = 1.
    - FlushD = FlushE = 0. A pending branch flush is deferred because PCSrcE is held by the frozen E stage.
    - Returns to RUN in the cycle MemReadyM=1. In that cycle outputs follow the RUN rules.
- Priority: memStall over lwStall over PCSrcE for the stall outputs. PCSrcE together with lwStall outside MEM_WAIT gives FlushD=1, FlushE=1, StallF=1, StallD=1.
- Timeout:
  - A wait counter (clog2(TIMEOUT+1) bits) increments every cycle memStall=1 and clears whenever memStall=0.
  - When it reaches TIMEOUT, MemTimeout sets.
  - MemTimeout stays set until reset; the FSM keeps waiting.
- Counters:
  - StallCount increments on each cycle with (lwStall|memStall) outside INIT.
  - FlushCount increments on each cycle where FlushD is driven due to PCSrcE.
  - Both saturate at all-ones and never wrap.
  - CntClear zeroes both on the next edge and wins over a same-cycle increment.
- Reset values:
  - state INIT, wait counter 0, MemTimeout 0, StallCount 0, FlushCount 0.
  - Outputs during reset: StallF=1, FlushD=1, FlushE=1, others 0, Forward* per the combinational rule.
- Reset mid-MEM_WAIT: asynchronously returns the FSM to INIT and clears the wait counter and MemTimeout.

Test Plan:
- Release reset, all inputs 0 -> first cycle StallF=1, FlushD=1, FlushE=1; next cycle all 0; StallCount=0.
- RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=0 -> ForwardAE=2, ForwardEE=0. Drop RegWriteM -> ForwardAE=1. Set RdM=RdW=0 with Rs1E=0 -> ForwardAE=0.
- ResultSrcE0=1, RdE=3, Rs2D=3 for 1 cycle -> StallF=1, StallD=1, FlushE=1, FlushD=0; StallCount=1. Repeat with RdE=0 -> no stall.
- PCSrcE=1 together with a load-use hazard -> FlushD=1, FlushE=1, StallF=1; FlushCount increments by 1.
- MemReqM=1, MemReadyM=0 for 3 cycles, then MemReadyM=1 -> StallF/D/E/M=1 and FlushW=1 for 3 cycles, then all clear; StallCount=3; MemTimeout stays 0.
- MemReqM=1, MemReadyM=0 held for TIMEOUT=16 cycles -> MemTimeout=1 on the 16th edge and stays 1 after MemReadyM=1. Assert reset mid-wait -> MemTimeout=0 and state INIT immediately.
